uart_tx_serializer: RTL

- Byte-to-serial UART transmitter (8N1, LSB first). It is the responder side of the parser's tx_start/tx_data/tx_ready handshake.
- Accepts one byte per start pulse from the command parser, drives the board TX pin, and raises ready once the stop bit has completed.
- Sits between the command parser and the FPGA UART TX pad, in the clk domain.

---
 rtl/uart_defs_pkg.sv | 16 +
 rtl/uart_tx_serializer_if.sv | 14 +
 rtl/uart_tx_serializer_baud_counter.sv | 32 +++
 rtl/uart_tx_serializer.sv | 112 +++++++++++
 4 files changed

// File: rtl/uart_defs_pkg.sv
// uart_defs: shared constants for the UART blocks.
//   state_e                   : 3-bit FSM encoding shared by tx (and future rx)
//   UART_DEFAULT_CLKS_PER_BIT : 50 MHz / 115200 baud
//   DATA_BITS                 : payload bits per frame
package uart_defs;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_BITS                 = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;
endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_if: parser -> serializer byte handshake.
//   tx_start_i : start request from the parser
//   tx_data_i  : byte to send, sampled on the accepting edge
//   tx_ready_o : serializer idle / able to accept
// modport master = command parser, modport slave = serializer.
interface uart_tx_if;
  import uart_defs::*;
  logic                 tx_start_i;
  logic [DATA_BITS-1:0] tx_data_i;
  logic                 tx_ready_o;

  modport master (output tx_start_i, output tx_data_i, input  tx_ready_o);
  modport slave  (input  tx_start_i, input  tx_data_i, output tx_ready_o);
endinterface

// File: rtl/uart_tx_serializer_baud_counter.sv
// uart_baud_counter: free-running bit timer, counts 0..CLKS_PER_BIT-1.
//   clk, rstn : clock, synchronous active-low reset
//   clear     : hold the count at 0 (e.g. while the line is idle)
//   bit_end   : high during the last cycle of a bit period
module uart_baud_counter
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic bit_end
);
  localparam int            CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == LAST) && !clear;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || cnt_q == LAST) cnt_d = '0;
    else                        cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter, LSB first.
//   clk, rstn : clock, synchronous active-low reset
//   tx_if     : slave side of the parser handshake (start/data in, ready out)
//   tx_o      : serial line, idles high
// Optional even parity bit between data and stop: define UART_TX_PARITY_EN.
// All outputs come straight from flops.
module uart_tx_serializer
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        rstn,
  uart_tx_if.slave    tx_if,
  output logic        tx_o
);
  localparam int                       IW       = $clog2(DATA_BITS);
  localparam logic [IW-1:0]            LAST_BIT = IW'(DATA_BITS - 1);

  state_e               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IW-1:0]        bit_idx_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  // Counter sits at 0 while idle so the start bit gets a full N cycles.
  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (state_q == ST_IDLE),
    .bit_end(bit_end)
  );

  assign tx_o             = tx_q;
  assign tx_if.tx_ready_o = ready_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tx_if.tx_start_i && ready_q) begin
            shift_q   <= tx_if.tx_data_i;
            tx_q      <= 1'b0;
            ready_q   <= 1'b0;
            bit_idx_q <= '0;
            state_q   <= ST_START;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^tx_if.tx_data_i;
`endif
          end
        end
        ST_START: begin
          if (bit_end) begin
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= ST_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              // shift_q[1] is the bit that lands in [0] after this shift
              tx_q      <= shift_q[1];
              shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
